// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential 14-bit binary to 4-digit packed BCD converter
// Double-dabble, one iteration per clock; result register updated only on the final iteration.
module bin_to_bcd_seq #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [15:0]      bcds,
  output logic             ovf
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(9999);
  localparam logic [3:0]       LAST_IT = 4'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [15:0]        scratch_q, scratch_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               povf_q, povf_d;
  logic [15:0]        bcds_q, bcds_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic [15:0]        adj;
  logic [WIDTH+15:0]  cat;

  // Per-nibble add-3 correction, no carry between digits, then one-bit shift of {scratch, operand}.
  always_comb begin
    adj = scratch_q;
    for (int n = 0; n < 4; n++) begin
      if (scratch_q[4*n +: 4] >= 4'd5) begin
        adj[4*n +: 4] = scratch_q[4*n +: 4] + 4'd3;
      end
    end
    cat = {adj, opnd_q} << 1;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    scratch_d = scratch_q;
    opnd_d    = opnd_q;
    povf_d    = povf_q;
    bcds_d    = bcds_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d     = 4'd0;
        scratch_d = 16'h0000;
        if (start) begin
          state_d = SHIFT;
          if (bin > MAX_VAL) begin
            opnd_d = MAX_VAL;
            povf_d = 1'b1;
          end else begin
            opnd_d = bin;
            povf_d = 1'b0;
          end
        end
      end
      SHIFT: begin
        scratch_d = cat[WIDTH+15:WIDTH];
        opnd_d    = cat[WIDTH-1:0];
        cnt_d     = cnt_q + 4'd1;
        if (cnt_q == LAST_IT) begin
          bcds_d  = cat[WIDTH+15:WIDTH];
          ovf_d   = povf_q;
          done_d  = 1'b1;
          cnt_d   = 4'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      scratch_q <= 16'h0000;
      opnd_q    <= '0;
      povf_q    <= 1'b0;
      bcds_q    <= 16'h0000;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      scratch_q <= scratch_d;
      opnd_q    <= opnd_d;
      povf_q    <= povf_d;
      bcds_q    <= bcds_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign bcds = bcds_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - directed self-checking bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcds;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  bin_to_bcd_seq #(.WIDTH(14)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcds  (bcds),
    .ovf   (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulses start for one cycle, then samples on falling edges until done (bounded).
  // lat is the falling-edge index after the accept edge where done was seen (0 = timeout).
  task automatic run_conv(input logic [13:0] v, output int nbusy, output int lat);
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    @(negedge clk);
    start = 1'b0;
    bin   = 14'd0;
    nbusy = 0;
    lat   = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i > 1) @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b1;
    bin   = 14'd1234;
    repeat (3) @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    checks++; if (bcds !== 16'h0000) begin errors++; $display("FAIL reset_bcds: got %h want 0000", bcds); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_start_priority: busy got %b want 0", busy); end
  endtask

  task automatic test_basic;
    int nb, lat;
    run_conv(14'd1234, nb, lat);
    checks++; if (nb != 14) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 14", nb); end
    checks++; if (lat != 15) begin errors++; $display("FAIL basic_latency: got %0d want 15", lat); end
    checks++; if (bcds !== 16'h1234) begin errors++; $display("FAIL basic_bcds: got %h want 1234", bcds); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", ovf); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b want 0", done); end
  endtask

  task automatic test_values;
    logic [13:0] vin [6];
    logic [15:0] vexp [6];
    logic        vovf [6];
    int nb, lat;
    vin = '{14'd0, 14'd9999, 14'd10, 14'd12000, 14'd16383, 14'd42};
    vexp = '{16'h0000, 16'h9999, 16'h0010, 16'h9999, 16'h9999, 16'h0042};
    vovf = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 6; k++) begin
      run_conv(vin[k], nb, lat);
      checks++; if (lat != 15) begin errors++; $display("FAIL values_latency[%0d]: got %0d want 15", vin[k], lat); end
      checks++; if (bcds !== vexp[k]) begin errors++; $display("FAIL values_bcds[%0d]: got %h want %h", vin[k], bcds, vexp[k]); end
      checks++; if (ovf !== vovf[k]) begin errors++; $display("FAIL values_ovf[%0d]: got %b want %b", vin[k], ovf, vovf[k]); end
    end
  endtask

  task automatic test_start_ignored;
    int ndone;
    ndone = 0;
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd5678;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done) ndone++;
      start = (i == 3 || i == 13);
      bin   = (i == 3 || i == 13) ? 14'd1 : 14'd0;
    end
    start = 1'b0;
    checks++; if (ndone != 1) begin errors++; $display("FAIL ignored_done_count: got %0d want 1", ndone); end
    checks++; if (bcds !== 16'h5678) begin errors++; $display("FAIL ignored_bcds: got %h want 5678", bcds); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignored_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_reset_abort;
    int nb, lat, ndone;
    run_conv(14'd777, nb, lat);
    checks++; if (bcds !== 16'h0777) begin errors++; $display("FAIL abort_pre_bcds: got %h want 0777", bcds); end
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd8888;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bcds !== 16'h0000) begin errors++; $display("FAIL abort_bcds: got %h want 0000", bcds); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", done); end
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL abort_late_done: got %0d want 0", ndone); end
    run_conv(14'd321, nb, lat);
    checks++; if (bcds !== 16'h0321) begin errors++; $display("FAIL abort_next_bcds: got %h want 0321", bcds); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_seq [4];
    logic [15:0] last;
    logic        prev_busy;
    int k, last_i, unstable;
    exp_seq   = '{16'h0100, 16'h2500, 16'h0100, 16'h2500};
    k         = 0;
    last_i    = 0;
    unstable  = 0;
    last      = bcds;
    prev_busy = 1'b0;
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd100;
    for (int i = 1; i <= 62; i++) begin
      @(negedge clk);
      if (done) begin
        if (k < 4) begin
          checks++; if (bcds !== exp_seq[k]) begin errors++; $display("FAIL b2b_bcds[%0d]: got %h want %h", k, bcds, exp_seq[k]); end
        end
        if (k > 0) begin
          checks++; if (i - last_i != 15) begin errors++; $display("FAIL b2b_period[%0d]: got %0d want 15", k, i - last_i); end
        end
        last   = bcds;
        last_i = i;
        k++;
      end else if (bcds !== last) begin
        unstable++;
      end
      if (busy && !prev_busy) bin = (bin == 14'd100) ? 14'd2500 : 14'd100;
      prev_busy = busy;
    end
    start = 1'b0;
    checks++; if (k != 4) begin errors++; $display("FAIL b2b_done_count: got %0d want 4", k); end
    checks++; if (unstable != 0) begin errors++; $display("FAIL b2b_stability: got %0d changes want 0", unstable); end
    repeat (20) @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    bin   = 14'd0;
    test_reset;
    test_basic;
    test_values;
    test_start_ignored;
    test_reset_abort;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
